// File: rtl/ps2_frame_receiver_if.sv
// Byte-delivery bundle between the PS/2 frame receiver and the downstream character buffer.
interface ps2_frame_receiver_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       busy;

  modport master (
    output data_out, data_valid, parity_error, frame_error, busy
  );

  modport slave (
    input data_out, data_valid, parity_error, frame_error, busy
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: synchronises and deglitches the line pair, deserialises
// 11-bit frames and emits one-cycle byte / error strobes, with a stalled-frame timeout.
module ps2_frame_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic                   system_clk,
  input  logic                   reset,
  input  logic                   PS2_clk,
  input  logic                   PS2_data,
  ps2_frame_receiver_if.master   rx
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  logic                   filt_clk;
  logic [FC_W-1:0]        filt_cnt;
  logic                   filt_flip;
  logic                   fall_stb;
  logic                   sample;

  state_t                 state, state_n;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par_bit;
  logic [TO_W-1:0]        to_cnt;
  logic                   timeout;

  logic                   valid_n;
  logic                   parity_err_n;
  logic                   frame_err_n;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // The filter flips once FILTER_LEN consecutive samples disagree with its current level.
  assign filt_flip = (clk_s != filt_clk) && (filt_cnt == FC_W'(FILTER_LEN - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would make the synchroniser chain collapse into a single stage.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      fall_stb  <= 1'b0;
      sample    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_data};
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_flip) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
      fall_stb <= filt_flip && !clk_s;
      sample   <= data_s;
    end
  end

  assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n      = state;
    valid_n      = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;
    if (fall_stb) begin
      case (state)
        IDLE:   if (!sample) state_n = DATA;
        DATA:   if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if ((^{shift, par_bit}) && sample) begin
            valid_n = 1'b1;
          end else begin
            parity_err_n = !(^{shift, par_bit});
            frame_err_n  = !sample;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n     = IDLE;
      frame_err_n = 1'b1;
    end
  end

  // NOTE: the shift register is small and part of the defined reset state, so it is reset
  // like any other flop; a RAM-style buffer would be left unreset instead.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      bit_cnt         <= '0;
      shift           <= '0;
      par_bit         <= 1'b0;
      to_cnt          <= '0;
      rx.data_out     <= '0;
      rx.data_valid   <= 1'b0;
      rx.parity_error <= 1'b0;
      rx.frame_error  <= 1'b0;
      rx.busy         <= 1'b0;
    end else begin
      if (fall_stb) begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            shift   <= '0;
          end
          DATA: begin
            shift   <= {sample, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= sample;
          default: ;
        endcase
      end else if (timeout) begin
        shift <= '0;
      end

      if (state == IDLE || fall_stb) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;

      if (valid_n) rx.data_out <= shift;
      rx.data_valid   <= valid_n;
      rx.parity_error <= parity_err_n;
      rx.frame_error  <= frame_err_n;
      rx.busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: frames push expected strobes, a monitor pops them.
module tb_ps2_frame_receiver;

  localparam int HALF    = 100;
  localparam int TIMEOUT = 1000;

  logic system_clk = 1'b0;
  logic reset      = 1'b1;
  logic ps2_clk    = 1'b1;
  logic ps2_data   = 1'b1;

  ps2_frame_receiver_if bus ();

  ps2_frame_receiver #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TO_W          (10)
  ) dut (
    .system_clk(system_clk),
    .reset     (reset),
    .PS2_clk   (ps2_clk),
    .PS2_data  (ps2_data),
    .rx        (bus)
  );

  always #5 system_clk = ~system_clk;

  typedef struct packed {
    logic [2:0] flags;  // {data_valid, parity_error, frame_error}
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] ev;
  logic [2:0] prev_ev = 3'b000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Strobe monitor: every pulse must match the oldest expectation and last one cycle.
  initial begin
    forever begin
      @(negedge system_clk);
      ev = {bus.data_valid, bus.parity_error, bus.frame_error};
      if (ev != 3'b000) begin
        check("pulse_width", {29'd0, prev_ev}, 0);
        if (sb_q.size() == 0) begin
          check("unexpected_event", {29'd0, ev}, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("event_flags", {29'd0, ev}, {29'd0, e.flags});
          if (e.flags[2]) check("event_data", {24'd0, bus.data_out}, {24'd0, e.data});
        end
      end
      prev_ev = ev;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge system_clk);
    ps2_data = b;
    if (glitch) begin
      repeat (40) @(negedge system_clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge system_clk);
      ps2_clk = 1'b1;
      repeat (HALF - 43) @(negedge system_clk);
    end else begin
      repeat (HALF) @(negedge system_clk);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      repeat (40) @(negedge system_clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge system_clk);
      ps2_clk = 1'b0;
      repeat (HALF - 43) @(negedge system_clk);
    end else begin
      repeat (HALF) @(negedge system_clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge system_clk);
    check(tag, sb_q.size(), 0);
    repeat (5) @(negedge system_clk);
    check({tag, "_busy"}, {31'd0, bus.busy}, 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit glitch);
    exp_t e;
    logic par_ok;
    par_ok = ^{d, par};
    e.data  = d;
    e.flags = (par_ok && stop) ? 3'b100 : {1'b0, !par_ok, !stop};
    sb_q.push_back(e);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    ps2_data = 1'b1;
    wait_drain("frame_drain");
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'h5A;

    repeat (3) @(negedge system_clk);
    check("rst_data_out", {24'd0, bus.data_out}, 0);
    check("rst_strobes", {29'd0, bus.data_valid, bus.parity_error, bus.frame_error}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    reset = 1'b0;
    repeat (20) @(negedge system_clk);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("parity_err_keeps_data", {24'd0, bus.data_out}, 32'h00);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("good_1c", {24'd0, bus.data_out}, 32'h1C);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("both_err_keeps_data", {24'd0, bus.data_out}, 32'h1C);
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    check("stop_err_keeps_data", {24'd0, bus.data_out}, 32'h1C);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check("good_f0", {24'd0, bus.data_out}, 32'hF0);

    // Stalled frame: start plus five data bits, then the clock stays high.
    sb_q.push_back('{flags: 3'b001, data: 8'h00});
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(partial[i], 1'b0);
    repeat (20) @(negedge system_clk);
    check("busy_mid_frame", {31'd0, bus.busy}, 1);
    repeat (TIMEOUT + 10) @(negedge system_clk);
    wait_drain("timeout_drain");
    check("timeout_keeps_data", {24'd0, bus.data_out}, 32'hF0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("good_5a_after_timeout", {24'd0, bus.data_out}, 32'h5A);

    @(negedge system_clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge system_clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge system_clk);
    check("idle_glitch_busy", {31'd0, bus.busy}, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("glitched_1c", {24'd0, bus.data_out}, 32'h1C);

    // Reset after four data bits: no strobe may appear for the lost frame.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i], 1'b0);
    repeat (5) @(negedge system_clk);
    check("busy_before_reset", {31'd0, bus.busy}, 1);
    reset = 1'b1;
    #1;
    check("midrst_data_out", {24'd0, bus.data_out}, 0);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_strobes", {29'd0, bus.data_valid, bus.parity_error, bus.frame_error}, 0);
    ps2_data = 1'b1;
    repeat (3) @(negedge system_clk);
    reset = 1'b0;
    repeat (20) @(negedge system_clk);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("good_5a_after_reset", {24'd0, bus.data_out}, 32'h5A);

    repeat (50) @(negedge system_clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
